// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD combinational read ports, NWRITE write ports,
// same-cycle write bypass, hardwired r0 and a pending-write scoreboard for hazard checks.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) (
    input  logic                     clk_in,
    input  logic                     rstn_in,
    input  logic                     rdy_in,
    input  logic [NREAD-1:0]         re_i,
    input  logic [NREAD*ADDR_W-1:0]  raddr_i,
    output logic [NREAD*DATA_W-1:0]  rdata_o,
    output logic [NREAD-1:0]         rbusy_o,
    input  logic [NWRITE-1:0]        we_i,
    input  logic [NWRITE*ADDR_W-1:0] waddr_i,
    input  logic [NWRITE*DATA_W-1:0] wdata_i,
    input  logic                     rsv_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic                     rsv_ok_o,
    output logic [ADDR_W:0]          busy_cnt_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   cnt_reg;
    logic [ADDR_W:0]   cnt_next;

    logic [ADDR_W-1:0] waddr [NWRITE];
    logic [DATA_W-1:0] wdata [NWRITE];
    logic [NWRITE-1:0] wr_eff;

    genvar gi;
    generate
        for (gi = 0; gi < NWRITE; gi++) begin : g_wr
            assign waddr[gi]  = waddr_i[gi*ADDR_W +: ADDR_W];
            assign wdata[gi]  = wdata_i[gi*DATA_W +: DATA_W];
            assign wr_eff[gi] = we_i[gi] && rdy_in && (waddr[gi] != '0);
        end

        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [ADDR_W-1:0] raddr;
            logic              hit;
            logic [DATA_W-1:0] byp;

            assign raddr = raddr_i[gi*ADDR_W +: ADDR_W];

            // Ascending scan so the highest matching write port supplies the bypass data.
            always_comb begin
                hit = 1'b0;
                byp = '0;
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr_eff[j] && (waddr[j] == raddr)) begin
                        hit = 1'b1;
                        byp = wdata[j];
                    end
                end
            end

            assign rdata_o[gi*DATA_W +: DATA_W] =
                (!re_i[gi] || raddr == '0) ? '0 : (hit ? byp : mem_reg[raddr]);
            assign rbusy_o[gi] = re_i[gi] && (raddr != '0) && busy_reg[raddr] && !hit;
        end
    endgenerate

    logic rsv_hit;
    always_comb begin
        rsv_hit = 1'b0;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_eff[j] && (waddr[j] == rsv_addr_i)) rsv_hit = 1'b1;
        end
    end

    assign rsv_ok_o = rsv_i && rdy_in &&
                      ((rsv_addr_i == '0) || !busy_reg[rsv_addr_i] || rsv_hit);

    // Clears first, then the set: a new producer reserving a register being written wins.
    always_comb begin
        busy_next = busy_reg;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_eff[j]) busy_next[waddr[j]] = 1'b0;
        end
        if (rsv_ok_o && (rsv_addr_i != '0)) busy_next[rsv_addr_i] = 1'b1;
    end

    always_comb begin
        cnt_next = '0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_next = cnt_next + (ADDR_W+1)'(busy_next[r]);
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    // Later ports overwrite earlier ones on an address collision.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            for (int r = 0; r < DEPTH; r++) mem_reg[r] <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_eff[j]) mem_reg[waddr[j]] <= wdata[j];
            end
        end
    end

    assign busy_cnt_o = cnt_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 2 ** AW;

    logic             clk_in = 1'b0;
    logic             rstn_in = 1'b0;
    logic             rdy_in;
    logic [NR-1:0]    re_i;
    logic [NR*AW-1:0] raddr_i;
    logic [NR*DW-1:0] rdata_o;
    logic [NR-1:0]    rbusy_o;
    logic [NW-1:0]    we_i;
    logic [NW*AW-1:0] waddr_i;
    logic [NW*DW-1:0] wdata_i;
    logic             rsv_i;
    logic [AW-1:0]    rsv_addr_i;
    logic             rsv_ok_o;
    logic [AW:0]      busy_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) dut (
        .clk_in(clk_in), .rstn_in(rstn_in), .rdy_in(rdy_in),
        .re_i(re_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .rbusy_o(rbusy_o),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .rsv_i(rsv_i), .rsv_addr_i(rsv_addr_i), .rsv_ok_o(rsv_ok_o),
        .busy_cnt_o(busy_cnt_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 0;
        end
    endtask

    function automatic int popcount_busy();
        int n = 0;
        for (int r = 0; r < DEPTH; r++) n += m_busy[r];
        return n;
    endfunction

    // Index of the last write port effectively writing address a this cycle, or -1.
    function automatic int last_writer(input logic [AW-1:0] a);
        int w = -1;
        for (int j = 0; j < NW; j++) begin
            if (we_i[j] && rdy_in && waddr_i[j*AW +: AW] != 0 && waddr_i[j*AW +: AW] == a) w = j;
        end
        return w;
    endfunction

    task automatic idle();
        rdy_in = 1'b1; re_i = '0; raddr_i = '0; we_i = '0; waddr_i = '0; wdata_i = '0;
        rsv_i = 1'b0; rsv_addr_i = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        re_i[k] = 1'b1;
        raddr_i[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
        we_i[j] = 1'b1;
        waddr_i[j*AW +: AW] = AW'(a);
        wdata_i[j*DW +: DW] = d;
    endtask

    // Called just after a negedge with inputs applied; checks this cycle, advances the model.
    task automatic step();
        logic [AW-1:0] a;
        logic [DW-1:0] exp_d;
        bit exp_b, exp_ok;
        int w;
        #1;
        for (int k = 0; k < NR; k++) begin
            a = raddr_i[k*AW +: AW];
            w = last_writer(a);
            if (!re_i[k] || a == 0) begin
                exp_d = '0; exp_b = 0;
            end else if (w >= 0) begin
                exp_d = wdata_i[w*DW +: DW]; exp_b = 0;
            end else begin
                exp_d = m_mem[a]; exp_b = m_busy[a];
            end
            check($sformatf("rdata%0d", k), 64'(rdata_o[k*DW +: DW]), 64'(exp_d));
            check($sformatf("rbusy%0d", k), 64'(rbusy_o[k]), 64'(exp_b));
        end
        exp_ok = rsv_i && rdy_in && (rsv_addr_i == 0 || !m_busy[rsv_addr_i] || last_writer(rsv_addr_i) >= 0);
        check("rsv_ok", 64'(rsv_ok_o), 64'(exp_ok));
        check("busy_cnt", 64'(busy_cnt_o), 64'(popcount_busy()));
        if (rdy_in) begin
            for (int r = 1; r < DEPTH; r++) begin
                w = last_writer(AW'(r));
                if (w >= 0) begin
                    m_mem[r]  = wdata_i[w*DW +: DW];
                    m_busy[r] = 0;
                end
            end
            if (exp_ok && rsv_addr_i != 0) m_busy[rsv_addr_i] = 1;
        end
        @(negedge clk_in);
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk_in);
        rstn_in = 1'b1;

        // Reset state at addresses 0, 5, 31
        set_rd(0, 0); set_rd(1, 5); step();
        idle(); set_rd(0, 31); set_rd(1, 31); rsv_i = 1'b0; step();

        // Same-address dual write: port1 wins for bypass and array
        idle(); set_wr(0, 3, 32'hDEADBEEF); set_wr(1, 3, 32'h12345678); set_rd(0, 3);
        #1 check("bypass_r3", 64'(rdata_o[0 +: DW]), 64'h12345678);
        step();
        idle(); set_rd(0, 3);
        #1 check("array_r3", 64'(rdata_o[0 +: DW]), 64'h12345678);
        step();
        idle(); set_wr(0, 0, 32'hFFFF0000); set_wr(1, 0, 32'h0000FFFF); set_rd(0, 0); set_rd(1, 0); step();
        idle(); set_rd(1, 0); step();

        // Scoreboard on r7
        idle(); rsv_i = 1'b1; rsv_addr_i = 5'd7;
        #1 check("rsv7_ok", 64'(rsv_ok_o), 64'd1);
        step();
        idle(); set_rd(0, 7); rsv_i = 1'b1; rsv_addr_i = 5'd7;
        #1 check("rsv7_again", 64'(rsv_ok_o), 64'd0);
        check("cnt_after_rsv7", 64'(busy_cnt_o), 64'd1);
        check("rbusy_r7", 64'(rbusy_o[0]), 64'd1);
        step();
        idle(); set_wr(0, 7, 32'h55); rsv_i = 1'b1; rsv_addr_i = 5'd7; set_rd(0, 7); step();
        idle(); set_rd(0, 7);
        #1 check("r7_data", 64'(rdata_o[0 +: DW]), 64'h55);
        check("r7_still_busy", 64'(rbusy_o[0]), 64'd1);
        check("cnt_r7_rsv_clr", 64'(busy_cnt_o), 64'd1);
        step();

        // Reserve r1..r3 (clearing r7 alongside), then clear r1 and r2 together
        idle(); set_wr(1, 7, 32'h77); rsv_i = 1'b1; rsv_addr_i = 5'd1; step();
        idle(); rsv_i = 1'b1; rsv_addr_i = 5'd2; step();
        idle(); rsv_i = 1'b1; rsv_addr_i = 5'd3; step();
        idle(); set_wr(0, 1, 32'h11); set_wr(1, 2, 32'h22);
        #1 check("cnt_three", 64'(busy_cnt_o), 64'd3);
        step();
        idle();
        #1 check("cnt_one", 64'(busy_cnt_o), 64'd1);
        step();

        // Stall: nothing may change
        idle(); rdy_in = 1'b0; set_wr(0, 3, 32'hBAD0BAD0); set_wr(1, 9, 32'h9); set_rd(0, 3); set_rd(1, 9);
        rsv_i = 1'b1; rsv_addr_i = 5'd9; step();
        idle(); set_rd(0, 3); set_rd(1, 9); step();

        // Four busy registers, then asynchronous reset mid-cycle
        idle(); rsv_i = 1'b1; rsv_addr_i = 5'd4; step();
        idle(); rsv_i = 1'b1; rsv_addr_i = 5'd5; step();
        idle(); rsv_i = 1'b1; rsv_addr_i = 5'd6; step();
        idle(); set_rd(0, 3); set_rd(1, 1);
        #1 check("cnt_four", 64'(busy_cnt_o), 64'd4);
        #1 rstn_in = 1'b0;
        #1 check("rst_cnt", 64'(busy_cnt_o), 64'd0);
        check("rst_rbusy0", 64'(rbusy_o[0]), 64'd0);
        check("rst_rdata0", 64'(rdata_o[0 +: DW]), 64'd0);
        check("rst_rdata1", 64'(rdata_o[DW +: DW]), 64'd0);
        model_reset();
        @(negedge clk_in);
        rstn_in = 1'b1;

        // Randomised traffic with a narrow address window to force collisions
        for (int n = 0; n < 1500; n++) begin
            int span;
            span = ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 6;
            idle();
            rdy_in = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < NR; k++) if ($urandom_range(0, 3) != 0) set_rd(k, $urandom_range(0, span));
            for (int j = 0; j < NW; j++) if ($urandom_range(0, 1) != 0) set_wr(j, $urandom_range(0, span), $urandom);
            rsv_i = ($urandom_range(0, 1) != 0);
            rsv_addr_i = AW'($urandom_range(0, span));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
